// File: rtl/memory_access_ctrl.sv
// memory_access_ctrl
// Memory-stage data access sequencer. Takes the load/store held in the
// execute->memory latch, runs the request/grant/response handshake on the
// data-memory bus, aligns store data to byte lanes, extends load data, and
// recovers from bus timeouts and pipeline flushes.
module memory_access_ctrl #(
   parameter int XLEN    = 32,
   parameter int TMO_CYC = 255,
   parameter int TMO_W   = 8
) (
   input  logic            clk_i,
   input  logic            rst,
   input  logic            execute_vaild_i,
   input  logic            ED_is_load_i,
   input  logic            ED_is_store_i,
   input  logic [2:0]      ED_funct3_i,
   input  logic [XLEN-1:0] ED_addr_i,
   input  logic [XLEN-1:0] ED_wdata_i,
   input  logic            write_back_allow_in_i,
   input  logic            flush_i,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   output logic [3:0]      dmem_wstrb_o,
   input  logic            dmem_gnt_i,
   input  logic            dmem_rvalid_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic [XLEN-1:0] M_valM_o,
   output logic            memory_ready_o,
   output logic            memory_allow_in_o,
   output logic            mem_err_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);
   localparam logic [TMO_W-1:0] CNT_ONE = TMO_W'(1);

   // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b000, 3'b100: misaligned = 1'b0;
         3'b001, 3'b101: misaligned = a[0];
         default:        misaligned = (a != 2'b00);
      endcase
   endfunction

   // Byte-lane strobes for the access size at the given lane offset.
   function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b000, 3'b100: lane_strb = 4'b0001 << a;
         3'b001, 3'b101: lane_strb = 4'b0011 << a;
         default:        lane_strb = 4'b1111;
      endcase
   endfunction

   // Moves the low byte/halfword of the store data onto its bus lane; unused lanes read zero.
   function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [XLEN-1:0] wd);
      case (f3)
         3'b000, 3'b100: lane_wdata = XLEN'(wd[7:0]) << {a, 3'b000};
         3'b001, 3'b101: lane_wdata = XLEN'(wd[15:0]) << {a[1], 4'b0000};
         default:        lane_wdata = wd;
      endcase
   endfunction

   // Selects the addressed lane and sign/zero-extends it. Halfwords only reach
   // the bus with a[0]=0, so shifting by 8*a equals shifting by 16*a[1] there.
   function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [XLEN-1:0] rd);
      logic [XLEN-1:0] sh;
      logic [7:0]      b;
      logic [15:0]     h;
      sh = rd >> {a, 3'b000};
      b  = sh[7:0];
      h  = sh[15:0];
      case (f3)
         3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
         3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
         3'b100:  load_ext = XLEN'(b);
         3'b101:  load_ext = XLEN'(h);
         default: load_ext = rd;
      endcase
   endfunction

   logic [2:0]       state_r;
   logic [2:0]       state_nxt_s;
   logic             req_r;
   logic             we_r;
   logic [XLEN-1:0]  addr_r;
   logic [XLEN-1:0]  wdata_r;
   logic [3:0]       wstrb_r;
   logic [2:0]       f3_r;
   logic [1:0]       lane_r;
   logic [XLEN-1:0]  valm_r;
   logic             err_r;
   logic [TMO_W-1:0] cnt_r;

   logic mem_op_s;
   logic misal_s;
   logic tmo_hit_s;
   logic launch_s;
   logic misal_hit_s;
   logic grant_s;
   logic resp_s;
   logic tmo_s;

   assign mem_op_s  = execute_vaild_i & (ED_is_load_i | ED_is_store_i);
   assign misal_s   = misaligned(ED_funct3_i, ED_addr_i[1:0]);
   assign tmo_hit_s = (cnt_r == TMO_LIM);

   // Next-state selection and the one-cycle events that drive the datapath registers.
   always_comb begin
      state_nxt_s = state_r;
      launch_s    = 1'b0;
      misal_hit_s = 1'b0;
      grant_s     = 1'b0;
      resp_s      = 1'b0;
      tmo_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (mem_op_s & ~flush_i) begin
               if (misal_s) begin
                  state_nxt_s = S_DONE;
                  misal_hit_s = 1'b1;
               end else begin
                  state_nxt_s = S_REQ;
                  launch_s    = 1'b1;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_REQ: begin
            // A grant in the flush cycle still owes us a response, so drain it.
            if (dmem_gnt_i) begin
               grant_s     = 1'b1;
               state_nxt_s = flush_i ? S_DRAIN : S_WAIT;
            end else if (flush_i) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_WAIT: begin
            // A flush coinciding with the response has nothing left to drain.
            if (flush_i) begin
               state_nxt_s = dmem_rvalid_i ? S_IDLE : S_DRAIN;
            end else if (dmem_rvalid_i) begin
               state_nxt_s = S_DONE;
               resp_s      = 1'b1;
            end else if (tmo_hit_s) begin
               state_nxt_s = S_DONE;
               tmo_s       = 1'b1;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_DRAIN: begin
            if (dmem_rvalid_i | tmo_hit_s) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_DRAIN;
            end
         end
         S_DONE: begin
            if (write_back_allow_in_i | flush_i) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Bus request fields: captured on launch, held stable until the grant.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         req_r   <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= {XLEN{1'b0}};
         wdata_r <= {XLEN{1'b0}};
         wstrb_r <= 4'b0000;
         f3_r    <= 3'b000;
         lane_r  <= 2'b00;
      end else if (launch_s) begin
         req_r   <= 1'b1;
         we_r    <= ED_is_store_i;
         addr_r  <= {ED_addr_i[XLEN-1:2], 2'b00};
         wdata_r <= lane_wdata(ED_funct3_i, ED_addr_i[1:0], ED_wdata_i);
         wstrb_r <= lane_strb(ED_funct3_i, ED_addr_i[1:0]);
         f3_r    <= ED_funct3_i;
         lane_r  <= ED_addr_i[1:0];
      end else if ((state_r == S_REQ) && (state_nxt_s != S_REQ)) begin
         req_r   <= 1'b0;
      end else begin
         req_r   <= req_r;
      end
   end

   // Response timeout counter: restarts at grant, saturates at the limit.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         cnt_r <= {TMO_W{1'b0}};
      end else if (grant_s) begin
         cnt_r <= {TMO_W{1'b0}};
      end else if (((state_r == S_WAIT) || (state_r == S_DRAIN)) && !tmo_hit_s) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Result and error pulse: load data on response, zero on store/error, else hold.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         valm_r <= {XLEN{1'b0}};
         err_r  <= 1'b0;
      end else begin
         err_r <= misal_hit_s | tmo_s;
         if (resp_s) begin
            valm_r <= we_r ? {XLEN{1'b0}} : load_ext(f3_r, lane_r, dmem_rdata_i);
         end else if (misal_hit_s | tmo_s) begin
            valm_r <= {XLEN{1'b0}};
         end else begin
            valm_r <= valm_r;
         end
      end
   end

   assign dmem_req_o        = req_r;
   assign dmem_we_o         = we_r;
   assign dmem_addr_o       = addr_r;
   assign dmem_wdata_o      = wdata_r;
   assign dmem_wstrb_o      = wstrb_r;
   assign M_valM_o          = valm_r;
   assign mem_err_o         = err_r;
   assign memory_ready_o    = ((state_r == S_IDLE) & ~mem_op_s) | (state_r == S_DONE);
   assign memory_allow_in_o = ~execute_vaild_i | (memory_ready_o & write_back_allow_in_i);

endmodule

// File: tb/tb_memory_access_ctrl.sv
// tb_memory_access_ctrl
// Table of load/store vectors run through a small bus responder, with a
// scoreboard queue of expected results, plus hand sequences for flush,
// drain, timeout and reset corner cases.
module tb_memory_access_ctrl;

   logic        clk_i = 1'b0;
   logic        rst;
   logic        execute_vaild_i;
   logic        ED_is_load_i;
   logic        ED_is_store_i;
   logic [2:0]  ED_funct3_i;
   logic [31:0] ED_addr_i;
   logic [31:0] ED_wdata_i;
   logic        write_back_allow_in_i;
   logic        flush_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_wstrb_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic [31:0] M_valM_o;
   logic        memory_ready_o;
   logic        memory_allow_in_o;
   logic        mem_err_o;

   memory_access_ctrl #(.XLEN(32), .TMO_CYC(255), .TMO_W(8)) dut (
      .clk_i                 (clk_i),
      .rst                   (rst),
      .execute_vaild_i       (execute_vaild_i),
      .ED_is_load_i          (ED_is_load_i),
      .ED_is_store_i         (ED_is_store_i),
      .ED_funct3_i           (ED_funct3_i),
      .ED_addr_i             (ED_addr_i),
      .ED_wdata_i            (ED_wdata_i),
      .write_back_allow_in_i (write_back_allow_in_i),
      .flush_i               (flush_i),
      .dmem_req_o            (dmem_req_o),
      .dmem_we_o             (dmem_we_o),
      .dmem_addr_o           (dmem_addr_o),
      .dmem_wdata_o          (dmem_wdata_o),
      .dmem_wstrb_o          (dmem_wstrb_o),
      .dmem_gnt_i            (dmem_gnt_i),
      .dmem_rvalid_i         (dmem_rvalid_i),
      .dmem_rdata_i          (dmem_rdata_i),
      .M_valM_o              (M_valM_o),
      .memory_ready_o        (memory_ready_o),
      .memory_allow_in_o     (memory_allow_in_o),
      .mem_err_o             (mem_err_o)
   );

   // Free-running clock, rising edge active.
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gd;
      int          rd;
      int          stall;
      logic        bus;
      logic [3:0]  wstrb;
      logic [31:0] exp_wdata;
      logic [31:0] exp_valm;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] valm;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   vec_t        vecs[12];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] keep_valm = 32'h0;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int gd, input int rd,
                               input int stall, input logic bus, input logic [3:0] wstrb,
                               input logic [31:0] exp_wdata, input logic [31:0] exp_valm,
                               input logic exp_err);
      vec_t v;
      v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.gd = gd; v.rd = rd; v.stall = stall; v.bus = bus; v.wstrb = wstrb;
      v.exp_wdata = exp_wdata; v.exp_valm = exp_valm; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic start_op(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
      execute_vaild_i = 1'b1;
      ED_is_load_i    = ld;
      ED_is_store_i   = st;
      ED_funct3_i     = f3;
      ED_addr_i       = addr;
      ED_wdata_i      = wdata;
   endtask

   // Drives one vector, answers the bus, and compares at completion.
   task automatic run_vec(input vec_t v, input int idx);
      exp_t  e;
      exp_t  got;
      int    cyc;
      int    req_seen;
      int    wait_cyc;
      int    stall_left;
      bit    granted;
      bit    ready_seen;
      bit    done;
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk_i);
      start_op(v.ld, v.st, v.f3, v.addr, v.wdata);
      write_back_allow_in_i = (v.stall == 0) ? 1'b1 : 1'b0;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      e.valm = v.exp_valm;
      e.err  = v.exp_err;
      e.lat  = v.bus ? (2 + v.gd + v.rd) : 1;
      sb_q.push_back(e);
      cyc = 0; req_seen = 0; wait_cyc = 0; stall_left = v.stall;
      granted = 1'b0; ready_seen = 1'b0; done = 1'b0;
      while (!done && cyc < 60) begin
         @(negedge clk_i);
         cyc++;
         dmem_gnt_i    = 1'b0;
         dmem_rvalid_i = 1'b0;
         if (memory_ready_o) begin
            if (!ready_seen) begin
               ready_seen = 1'b1;
               if (sb_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL %s_sb: ready with no expected result queued", tag);
               end else begin
                  got = sb_q.pop_front();
                  chk32({tag, "_valm"}, M_valM_o, got.valm);
                  chk1({tag, "_err"}, mem_err_o, got.err);
                  chk32({tag, "_latency"}, 32'(cyc), 32'(got.lat));
                  chk32({tag, "_req_cycles"}, 32'(req_seen), v.bus ? 32'(v.gd + 1) : 32'd0);
                  keep_valm = got.valm;
               end
            end else begin
               chk32({tag, "_hold_valm"}, M_valM_o, v.exp_valm);
               chk1({tag, "_err_pulse"}, mem_err_o, 1'b0);
            end
            chk1({tag, "_allow_in"}, memory_allow_in_o, write_back_allow_in_i);
            if (stall_left > 1) begin
               stall_left--;
            end else begin
               write_back_allow_in_i = 1'b1;
               execute_vaild_i       = 1'b0;
               done                  = 1'b1;
            end
         end else if (dmem_req_o) begin
            req_seen++;
            if (req_seen == v.gd + 1) begin
               dmem_gnt_i = 1'b1;
               granted    = 1'b1;
               chk1({tag, "_we"}, dmem_we_o, v.st);
               chk32({tag, "_addr"}, dmem_addr_o, {v.addr[31:2], 2'b00});
               chk32({tag, "_wstrb"}, 32'(dmem_wstrb_o), 32'(v.wstrb));
               chk32({tag, "_wdata"}, dmem_wdata_o, v.exp_wdata);
            end
         end else if (granted) begin
            wait_cyc++;
            if (wait_cyc == v.rd) begin
               dmem_rvalid_i = 1'b1;
               dmem_rdata_i  = v.rdata;
            end
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: no completion within 60 cycles", tag);
         execute_vaild_i       = 1'b0;
         write_back_allow_in_i = 1'b1;
      end
   endtask

   // Bounds the whole run in case the DUT wedges somewhere unexpected.
   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // Main test sequence.
   initial begin
      int cnt;
      //           ld    st    f3      addr          wdata         rdata         gd rd st bus  strb     exp_wdata     exp_valm      err
      vecs[0]  = mk(1'b1, 1'b0, 3'b010, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 0, 1, 0, 1'b1, 4'b1111, 32'h00000000, 32'hDEADBEEF, 1'b0);
      vecs[1]  = mk(1'b1, 1'b0, 3'b000, 32'h00000103, 32'h00000000, 32'h80AABBCC, 1, 1, 0, 1'b1, 4'b1000, 32'h00000000, 32'hFFFFFF80, 1'b0);
      vecs[2]  = mk(1'b1, 1'b0, 3'b100, 32'h00000103, 32'h00000000, 32'h80AABBCC, 0, 2, 0, 1'b1, 4'b1000, 32'h00000000, 32'h00000080, 1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 3'b101, 32'h00000102, 32'h00000000, 32'h80AABBCC, 0, 1, 0, 1'b1, 4'b1100, 32'h00000000, 32'h000080AA, 1'b0);
      vecs[4]  = mk(1'b1, 1'b0, 3'b001, 32'h00000100, 32'h00000000, 32'h12348001, 0, 1, 0, 1'b1, 4'b0011, 32'h00000000, 32'hFFFF8001, 1'b0);
      vecs[5]  = mk(1'b0, 1'b1, 3'b000, 32'h00000101, 32'h00000012, 32'hFFFFFFFF, 5, 2, 0, 1'b1, 4'b0010, 32'h00001200, 32'h00000000, 1'b0);
      vecs[6]  = mk(1'b0, 1'b1, 3'b001, 32'h00000102, 32'h0000ABCD, 32'h00000000, 0, 1, 0, 1'b1, 4'b1100, 32'hABCD0000, 32'h00000000, 1'b0);
      vecs[7]  = mk(1'b0, 1'b1, 3'b010, 32'h00000104, 32'hCAFEF00D, 32'h00000000, 1, 3, 0, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h00000000, 1'b0);
      vecs[8]  = mk(1'b1, 1'b0, 3'b010, 32'h00000200, 32'h00000000, 32'h0BADCAFE, 2, 1, 4, 1'b1, 4'b1111, 32'h00000000, 32'h0BADCAFE, 1'b0);
      vecs[9]  = mk(1'b1, 1'b0, 3'b001, 32'h00000101, 32'h00000000, 32'h00000000, 0, 0, 0, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1);
      vecs[10] = mk(1'b1, 1'b0, 3'b010, 32'h00000102, 32'h00000000, 32'h00000000, 0, 0, 2, 1'b0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1);
      vecs[11] = mk(1'b1, 1'b0, 3'b100, 32'h00000101, 32'h00000000, 32'h11223344, 0, 1, 0, 1'b1, 4'b0010, 32'h00000000, 32'h00000033, 1'b0);

      rst = 1'b1;
      execute_vaild_i = 1'b0; ED_is_load_i = 1'b0; ED_is_store_i = 1'b0;
      ED_funct3_i = 3'b000; ED_addr_i = 32'h0; ED_wdata_i = 32'h0;
      write_back_allow_in_i = 1'b1; flush_i = 1'b0;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
      repeat (3) @(negedge clk_i);
      rst = 1'b0;
      @(negedge clk_i);
      chk1("rst_req", dmem_req_o, 1'b0);
      chk1("rst_we", dmem_we_o, 1'b0);
      chk32("rst_addr", dmem_addr_o, 32'h0);
      chk32("rst_wdata", dmem_wdata_o, 32'h0);
      chk32("rst_wstrb", 32'(dmem_wstrb_o), 32'h0);
      chk32("rst_valm", M_valM_o, 32'h0);
      chk1("rst_err", mem_err_o, 1'b0);
      chk1("rst_ready", memory_ready_o, 1'b1);
      chk1("rst_allow_in", memory_allow_in_o, 1'b1);

      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i], i);
      end

      // Flush while waiting for the response: drained, result untouched.
      @(negedge clk_i);
      start_op(1'b1, 1'b0, 3'b010, 32'h00000300, 32'h0);
      @(negedge clk_i);
      chk1("fw_req", dmem_req_o, 1'b1);
      dmem_gnt_i = 1'b1;
      @(negedge clk_i);
      dmem_gnt_i = 1'b0;
      chk1("fw_wait_ready", memory_ready_o, 1'b0);
      flush_i = 1'b1; execute_vaild_i = 1'b0;
      @(negedge clk_i);
      flush_i = 1'b0;
      chk1("fw_drain_ready", memory_ready_o, 1'b0);
      @(negedge clk_i);
      chk1("fw_drain_ready2", memory_ready_o, 1'b0);
      @(negedge clk_i);
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55555555;
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      chk1("fw_idle_ready", memory_ready_o, 1'b1);
      chk32("fw_valm_kept", M_valM_o, keep_valm);
      chk1("fw_err", mem_err_o, 1'b0);
      chk1("fw_req_low", dmem_req_o, 1'b0);

      // Grant and flush together in REQ: the owed response is drained.
      start_op(1'b1, 1'b0, 3'b010, 32'h00000310, 32'h0);
      @(negedge clk_i);
      dmem_gnt_i = 1'b1; flush_i = 1'b1; execute_vaild_i = 1'b0;
      @(negedge clk_i);
      dmem_gnt_i = 1'b0; flush_i = 1'b0;
      chk1("gf_drain_ready", memory_ready_o, 1'b0);
      chk1("gf_req", dmem_req_o, 1'b0);
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h77777777;
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      chk1("gf_idle_ready", memory_ready_o, 1'b1);
      chk32("gf_valm_kept", M_valM_o, keep_valm);

      // Flush in REQ without grant, then a stray response in IDLE.
      start_op(1'b0, 1'b1, 3'b010, 32'h00000320, 32'h12345678);
      @(negedge clk_i);
      flush_i = 1'b1; execute_vaild_i = 1'b0;
      @(negedge clk_i);
      flush_i = 1'b0;
      chk1("fr_req_dropped", dmem_req_o, 1'b0);
      chk1("fr_ready", memory_ready_o, 1'b1);
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h99999999;
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      chk32("stray_rvalid_valm", M_valM_o, keep_valm);
      chk1("stray_rvalid_ready", memory_ready_o, 1'b1);

      // Bus timeout: granted load with no response.
      start_op(1'b1, 1'b0, 3'b010, 32'h00000400, 32'h0);
      @(negedge clk_i);
      dmem_gnt_i = 1'b1;
      @(negedge clk_i);
      dmem_gnt_i = 1'b0;
      cnt = 2;
      while (memory_ready_o !== 1'b1 && cnt < 400) begin
         @(negedge clk_i);
         cnt++;
      end
      if (memory_ready_o !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL tmo_wait: no completion after %0d cycles", cnt);
      end else begin
         chk1("tmo_cycle_window", (cnt >= 256 && cnt <= 260) ? 1'b1 : 1'b0, 1'b1);
         chk1("tmo_err", mem_err_o, 1'b1);
         chk32("tmo_valm", M_valM_o, 32'h0);
      end
      execute_vaild_i = 1'b0;
      @(negedge clk_i);
      chk1("tmo_err_pulse", mem_err_o, 1'b0);
      chk1("tmo_idle_ready", memory_ready_o, 1'b1);

      // Reset while waiting for a store ack: everything back to zero.
      keep_valm = 32'h0;
      start_op(1'b1, 1'b0, 3'b100, 32'h00000501, 32'h0);
      @(negedge clk_i);
      dmem_gnt_i = 1'b1;
      @(negedge clk_i);
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000C300;
      execute_vaild_i = 1'b0;
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      chk32("pre_rst_valm", M_valM_o, 32'h000000C3);
      @(negedge clk_i);
      start_op(1'b0, 1'b1, 3'b010, 32'h00000504, 32'hA5A5A5A5);
      @(negedge clk_i);
      dmem_gnt_i = 1'b1;
      @(negedge clk_i);
      dmem_gnt_i = 1'b0;
      rst = 1'b1; execute_vaild_i = 1'b0;
      @(negedge clk_i);
      rst = 1'b0;
      chk1("mrst_req", dmem_req_o, 1'b0);
      chk1("mrst_we", dmem_we_o, 1'b0);
      chk32("mrst_addr", dmem_addr_o, 32'h0);
      chk32("mrst_wdata", dmem_wdata_o, 32'h0);
      chk32("mrst_wstrb", 32'(dmem_wstrb_o), 32'h0);
      chk32("mrst_valm", M_valM_o, 32'h0);
      chk1("mrst_err", mem_err_o, 1'b0);
      chk1("mrst_ready", memory_ready_o, 1'b1);

      chk32("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
